// File: rtl/ram_responder_if.sv
// RAM-side bus between the memory controller and a RAM responder, plus the
// shared ramstate encoding.
package cpu_types_pkg;
   typedef enum logic [1:0] {
      FREE   = 2'b00,
      BUSY   = 2'b01,
      ACCESS = 2'b10,
      ERROR  = 2'b11
   } ramstate_t;
endpackage

interface ram_responder_if;
   import cpu_types_pkg::*;

   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   ramstate_t   ramstate;

   modport master (
      output ramREN, ramWEN, ramaddr, ramstore,
      input  ramload, ramstate
   );

   modport slave (
      input  ramREN, ramWEN, ramaddr, ramstore,
      output ramload, ramstate
   );
endinterface

// File: rtl/ram_responder.sv
// Word-addressed RAM with a fixed request-to-ACCESS latency, reporting progress
// on ramstate so the controller's stall paths see real wait cycles.
module ram_responder
   import cpu_types_pkg::*;
#(
   parameter int LAT   = 2,
   parameter int DEPTH = 16384
) (
   input logic            CLK,
   input logic            nRST,
   ram_responder_if.slave rif
);
   localparam int          AW     = $clog2(DEPTH);
   localparam logic [3:0]  LAT_M1 = 4'(LAT - 1);
   localparam logic [63:0] LIMIT  = 64'(DEPTH) * 64'd4;

   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_reg;

   logic        valid_reg, valid_next;
   logic [31:0] t_addr_reg, t_addr_next;
   logic        t_wen_reg, t_wen_next;
   logic [3:0]  cnt_reg, cnt_next;

   logic          req;
   logic          match;
   logic          misaligned;
   logic          out_of_range;
   logic          mem_we;
   logic [AW-1:0] index;
   ramstate_t     state;

   assign index        = rif.ramaddr[AW+1:2];
   assign req          = rif.ramREN | rif.ramWEN;
   assign misaligned   = rif.ramaddr[1:0] != 2'b00;
   assign out_of_range = {32'h0, rif.ramaddr} >= LIMIT;
   assign match        = valid_reg && (rif.ramaddr == t_addr_reg) && (rif.ramWEN == t_wen_reg);
   assign mem_we       = (state == ACCESS) && t_wen_reg;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid_reg  <= 1'b0;
         t_addr_reg <= 32'h0;
         t_wen_reg  <= 1'b0;
         cnt_reg    <= 4'd0;
      end else begin
         valid_reg  <= valid_next;
         t_addr_reg <= t_addr_next;
         t_wen_reg  <= t_wen_next;
         cnt_reg    <= cnt_next;
      end
   end

   // The read port runs every cycle; the address is stable through BUSY, so the
   // word captured on the last BUSY edge is exactly what ACCESS must present.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem[index] <= rif.ramstore;
      end
      rdata_reg <= mem[index];
   end

   always_comb begin
      valid_next  = valid_reg;
      t_addr_next = t_addr_reg;
      t_wen_next  = t_wen_reg;
      cnt_next    = cnt_reg;
      unique case (state)
         ERROR, FREE: valid_next = 1'b0;
         BUSY: begin
            if (!match) begin
               valid_next  = 1'b1;
               t_addr_next = rif.ramaddr;
               t_wen_next  = rif.ramWEN;
               cnt_next    = LAT_M1;
            end else if (cnt_reg != 4'd0) begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         ACCESS: valid_next = 1'b0;
         default: valid_next = 1'b0;
      endcase
   end

   always_comb begin
      if ((rif.ramREN && rif.ramWEN) || (req && (misaligned || out_of_range))) begin
         state = ERROR;
      end else if (!req) begin
         state = FREE;
      end else if (match && (cnt_reg == 4'd0)) begin
         state = ACCESS;
      end else begin
         state = BUSY;
      end
      rif.ramstate = state;
      rif.ramload  = ((state == ACCESS) && !rif.ramWEN) ? rdata_reg : 32'h0;
   end
endmodule
